// File: rtl/data_path_if.sv
// data_path_pkg / data_path_if
//
// The package holds the decoded instruction type shared by the K-and-S
// datapath, its control unit and anything that observes the decode.
//
// The interface bundles the datapath's control word, the RAM bus and the
// status returned to the control unit.
//   master : control unit / RAM side. It drives the strobes, selects,
//            operation and RAM read data, and observes the address, the
//            write data, the decode and the flags.
//   slave  : datapath side, with the opposite directions.
package data_path_pkg;
    typedef enum logic [3:0] {
        I_NOP, I_BRANCH, I_BZERO, I_BNEG, I_BNZERO, I_BNNEG, I_BOV, I_BNOV,
        I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT
    } decoded_instruction_type;
endpackage

interface data_path_if;
    import data_path_pkg::*;

    logic                    branch;
    logic                    pc_enable;
    logic                    ir_enable;
    logic                    write_reg_enable;
    logic                    addr_sel;
    logic                    c_sel;
    logic [1:0]              operation;
    logic                    flags_reg_enable;
    logic [15:0]             data_in;
    logic [4:0]              ram_addr;
    logic [15:0]             data_out;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op;
    logic                    neg_op;
    logic                    unsigned_overflow;
    logic                    signed_overflow;

    modport master (
        output branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel,
               operation, flags_reg_enable, data_in,
        input  ram_addr, data_out, decoded_instruction,
               zero_op, neg_op, unsigned_overflow, signed_overflow
    );

    modport slave (
        input  branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel,
               operation, flags_reg_enable, data_in,
        output ram_addr, data_out, decoded_instruction,
               zero_op, neg_op, unsigned_overflow, signed_overflow
    );
endinterface

// File: rtl/data_path.sv
// data_path
//
// Datapath of the K-and-S processor. It contains the 5-bit PC, the 16-bit IR
// and its decoder, a 4 x 16-bit register file, the ALU and the flags register.
// Each cycle it executes the control word supplied by the control unit.
//
// Ports:
//   clk   : system clock, rising edge.
//   rst_n : asynchronous active-low reset. PC, IR, registers and flags go to 0.
//   bus   : data_path_if.slave. Control strobes and selects, the ALU
//           operation and the RAM read data come in. The RAM address, the RAM
//           write data, the decoded instruction and the registered flags go out.
module data_path
    import data_path_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    data_path_if.slave bus
);
    typedef struct packed {
        logic [15:0] result;
        logic        zero;
        logic        neg;
        logic        uov;
        logic        sov;
    } alu_out_t;

    logic [4:0]              pc;
    logic [15:0]             ir;
    logic [15:0]             regs [4];
    logic                    zero_q, neg_q, uov_q, sov_q;
    decoded_instruction_type dec;
    logic [15:0]             a_op, b_op, wdata;
    logic [1:0]              dest;
    alu_out_t                alu;

    // ir[7] is not part of any instruction field.
    logic unused_ir_bit;
    assign unused_ir_bit = ir[7];

    function automatic alu_out_t alu_eval(input logic [1:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        alu_out_t           o;
        logic [16:0]        wide;
        logic signed [15:0] sa, sb, sr;
        o    = '0;
        wide = '0;
        sa   = a;
        sb   = b;
        case (op)
            2'b00: o.result = a | b;
            2'b01: begin
                wide     = {1'b0, a} + {1'b0, b};
                o.result = wide[15:0];
                o.uov    = wide[16];
            end
            2'b10: begin
                // The top bit of the 17-bit difference is the borrow (a < b).
                wide     = {1'b0, a} - {1'b0, b};
                o.result = wide[15:0];
                o.uov    = wide[16];
            end
            default: o.result = a & b;
        endcase
        sr = o.result;
        if (op == 2'b01)
            o.sov = (sa[15] == sb[15]) && (sr[15] != sa[15]);
        else if (op == 2'b10)
            o.sov = (sa[15] != sb[15]) && (sr[15] != sa[15]);
        o.zero = (o.result == 16'h0000);
        o.neg  = o.result[15];
        return o;
    endfunction

    always_comb begin
        dec = I_NOP;
        case (ir[15:8])
            8'h01: dec = I_BRANCH;
            8'h02: dec = I_BZERO;
            8'h03: dec = I_BNEG;
            8'h04: dec = I_BNZERO;
            8'h05: dec = I_BNNEG;
            8'h06: dec = I_BOV;
            8'h07: dec = I_BNOV;
            8'h81: dec = I_LOAD;
            8'h82: dec = I_STORE;
            8'h91: dec = I_MOVE;
            8'hA1: dec = I_ADD;
            8'hA2: dec = I_SUB;
            8'hA3: dec = I_AND;
            8'hA4: dec = I_OR;
            8'hFF: dec = I_HALT;
            default: dec = I_NOP;
        endcase
    end

    // A MOVE is executed as A | 0, so B is forced to zero.
    assign a_op  = regs[ir[3:2]];
    assign b_op  = (dec == I_MOVE) ? 16'h0000 : regs[ir[1:0]];
    assign alu   = alu_eval(bus.operation, a_op, b_op);

    assign dest  = (dec == I_LOAD) ? ir[6:5] : ir[5:4];
    assign wdata = bus.c_sel ? alu.result : bus.data_in;

    assign bus.ram_addr            = bus.addr_sel ? ir[4:0] : pc;
    assign bus.data_out            = regs[ir[6:5]];
    assign bus.decoded_instruction = dec;
    assign bus.zero_op             = zero_q;
    assign bus.neg_op              = neg_q;
    assign bus.unsigned_overflow   = uov_q;
    assign bus.signed_overflow     = sov_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= 5'd0;
        else if (bus.pc_enable)
            pc <= bus.branch ? ir[4:0] : pc + 5'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ir <= 16'h0000;
        else if (bus.ir_enable)
            ir <= bus.data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++)
                regs[i] <= 16'h0000;
        end else if (bus.write_reg_enable) begin
            regs[dest] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            uov_q  <= 1'b0;
            sov_q  <= 1'b0;
        end else if (bus.flags_reg_enable) begin
            zero_q <= alu.zero;
            neg_q  <= alu.neg;
            uov_q  <= alu.uov;
            sov_q  <= alu.sov;
        end
    end
endmodule

// File: doc/data_path.md
# data_path

Datapath of the K-and-S processor: program counter, instruction register, instruction decoder, 4×16-bit register file, ALU and flags register. Executes the control word issued by `control_unit` each cycle and returns the decoded instruction and registered ALU flags. Drives the RAM address and write data, and accepts RAM read data for instruction fetch and LOAD.

## Interface
- Parameters: none. Widths are fixed by the ISA: 16-bit data, 5-bit address, 4 registers.
- `clk` in 1 — system clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `branch` in 1 — on a PC update, select the branch target instead of PC+1.
- `pc_enable` in 1 — PC update strobe.
- `ir_enable` in 1 — IR load strobe; IR captures `data_in`.
- `write_reg_enable` in 1 — register file write strobe.
- `addr_sel` in 1 — RAM address select: 1 = `ir[4:0]`, 0 = PC.
- `c_sel` in 1 — register write data select: 1 = ALU result, 0 = `data_in`.
- `operation` in 2 — ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND.
- `flags_reg_enable` in 1 — flags register load strobe.
- `data_in` in 16 — RAM read data.
- `ram_addr` out 5 — RAM address.
- `data_out` out 16 — RAM write data.
- `decoded_instruction` out `decoded_instruction_type` — decode of the IR.
- `zero_op`, `neg_op`, `unsigned_overflow`, `signed_overflow` out 1 each — registered flags.

## Operation
- **ISA:** opcode is `ir[15:8]`.
  - `8'h00` I_NOP.
  - `8'h01` I_BRANCH, `8'h02` I_BZERO, `8'h03` I_BNEG, `8'h04` I_BNZERO, `8'h05` I_BNNEG, `8'h06` I_BOV, `8'h07` I_BNOV. Target is `ir[4:0]`.
  - `8'h81` I_LOAD and `8'h82` I_STORE. Register is `ir[6:5]`, address is `ir[4:0]`.
  - `8'h91` I_MOVE, with c = `ir[5:4]` and a = `ir[3:2]`.
  - `8'hA1` I_ADD, `8'hA2` I_SUB, `8'hA3` I_AND, `8'hA4` I_OR, with c = `ir[5:4]`, a = `ir[3:2]`, b = `ir[1:0]`.
  - `8'hFF` I_HALT.
  - Any other opcode decodes to I_NOP.
- **Decode:** purely combinational from the IR.
- **PC (5-bit):**
  - On `pc_enable`: PC ← `branch` ? `ir[4:0]` : PC+1.
  - Increment wraps 31→0.
  - `branch` has no effect without `pc_enable`.
  - The datapath does not evaluate branch conditions; it jumps whenever `branch` is asserted.
- **RAM address:** `ram_addr` = `addr_sel` ? `ir[4:0]` : PC, combinational.
- **IR (16-bit):** loads `data_in` on `ir_enable`.
- **RAM write data:** `data_out` = R[`ir[6:5]`], combinational (STORE source).
- **ALU operands:**
  - A = R[`ir[3:2]`].
  - B = R[`ir[1:0]`], forced to 0 when decoded is I_MOVE, so that OR yields a copy of A.
- **ALU arithmetic:**
  - Result is 16 bits, modulo 2^16.
  - ADD: unsigned_overflow = carry out of bit 15; signed_overflow = A[15]==B[15] && R[15]!=A[15].
  - SUB (A−B): unsigned_overflow = borrow (A < B unsigned); signed_overflow = A[15]!=B[15] && R[15]!=A[15].
  - AND/OR: both overflow flags are 0.
  - zero = (R == 0); neg = R[15].
- **Register write:**
  - On `write_reg_enable`, destination = `ir[6:5]` when decoded is I_LOAD, else `ir[5:4]`.
  - Write data = `c_sel` ? ALU result : `data_in`.
  - Writes take effect at the clock edge; reads are combinational and return the old value in the write cycle.
- **Flags:** on `flags_reg_enable`, all four flags load from the current ALU result; otherwise they hold.
- **Simultaneous events:** all strobes are independent and may coincide.
  - `ir_enable` + `pc_enable`: IR captures `data_in` and the PC advances from its pre-edge value.
  - `write_reg_enable` + `flags_reg_enable`: register and flags update from the same ALU result.

## Timing
- **Reset (asynchronous, any cycle, including mid-instruction):**
  - PC = 0, IR = 0 (decodes I_NOP), all registers = 0, all flags = 0.
  - Therefore `ram_addr` = 0 (with `addr_sel` = 0), `data_out` = 0, `decoded_instruction` = I_NOP.
  - Release is synchronous to the next rising edge.
- **Register latency:** PC, IR, register file and flags update one edge after their strobe is sampled high.
- **Combinational paths:** `ram_addr`, `data_out`, `decoded_instruction` and the ALU are combinational; `decoded_instruction` is valid in the cycle after an IR load.
- **`data_in`:** sampled unregistered at the edge.
  - RAM read latency is owned by `control_unit` sequencing: address is presented one cycle, data is captured on the next.
- **Flags visibility:** flags are visible to `control_unit` the cycle after `flags_reg_enable`.

## Test plan
- Reset, then apply `data_in` = 16'h8103 with `ir_enable` = `pc_enable` = 1 for one cycle → IR = 16'h8103, decoded = I_LOAD, PC = 1. Then `addr_sel` = 1 → `ram_addr` = 3.
- LOAD R1 ← 16'h7FFF and LOAD R2 ← 16'h0001 via `c_sel` = 0 writes. Then IR = 16'hA136 (ADD R3 ← R1+R2) with `operation` = 01 and `write_reg_enable` = `flags_reg_enable` = 1 → R3 = 16'h8000, neg = 1, signed_overflow = 1, unsigned_overflow = 0, zero = 0.
- R1 = 16'h0000, R2 = 16'h0001, SUB R3 ← R1−R2 → R3 = 16'hFFFF, unsigned_overflow = 1, neg = 1. AND of the same operands → 16'h0000, zero = 1, both overflow flags = 0.
- MOVE with IR = 16'h9124 and R1 = 16'h1234, R0 = 16'hFFFF, `operation` = 00, `c_sel` = 1 → R2 = 16'h1234. R0 does not affect the result.
- PC = 31 with `pc_enable` → PC = 0. IR = 16'h0114 with `branch` = `pc_enable` = 1 → PC = 20. `branch` = 1 with `pc_enable` = 0 → PC unchanged.
- Assert `rst_n` = 0 asynchronously mid-cycle after loading registers and flags → all outputs return to reset values immediately, without waiting for a clock edge.
